// File: rtl/if_fetch_if.sv
// Memory read bus shared between the fetch stage and the memory system.
// Latency: read data is valid two cycles after the cycle in which mem_read_en pulses.
// Backpressure: none; the memory always accepts a read pulse.
interface if_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_read_en;
  logic [7:0]  mem_data_in;

  modport master (
    output mem_addr,
    output mem_read_en,
    input  mem_data_in
  );

  modport slave (
    input  mem_addr,
    input  mem_read_en,
    output mem_data_in
  );
endinterface

// File: rtl/if_fetch.sv
// 6502 instruction fetch: reads opcode, operands and pointer bytes, resolves the effective address.
// Latency: N reads (1..5) at 3 cycles each; if_ready rises 3N+2 cycles after the accepted start.
// Backpressure: halt blocks a new start in IDLE; a start seen outside IDLE is ignored.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        if_start,
  input  logic [15:0] pc_in,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  if_fetch_if.master  mem,
  output logic [7:0]  opcode,
  output logic [3:0]  addr_mode,
  output logic [15:0] if_addr_out,
  output logic [15:0] if_pc_next,
  output logic        if_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESOLVE
  } state_t;

  localparam logic [3:0] M_IMP  = 4'd0;
  localparam logic [3:0] M_IMM  = 4'd1;
  localparam logic [3:0] M_ZP   = 4'd2;
  localparam logic [3:0] M_ZPX  = 4'd3;
  localparam logic [3:0] M_ZPY  = 4'd4;
  localparam logic [3:0] M_ABS  = 4'd5;
  localparam logic [3:0] M_ABSX = 4'd6;
  localparam logic [3:0] M_ABSY = 4'd7;
  localparam logic [3:0] M_INDX = 4'd8;
  localparam logic [3:0] M_INDY = 4'd9;
  localparam logic [3:0] M_REL  = 4'd10;
  localparam logic [3:0] M_IND  = 4'd11;

  // Addressing mode from the aaabbbcc opcode layout.
  function automatic logic [3:0] decode_mode(input logic [7:0] op);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic [3:0] m;
    aaa = op[7:5];
    bbb = op[4:2];
    cc  = op[1:0];
    m   = M_IMP;
    case (cc)
      2'b01: begin
        case (bbb)
          3'd0:    m = M_INDX;
          3'd1:    m = M_ZP;
          3'd2:    m = M_IMM;
          3'd3:    m = M_ABS;
          3'd4:    m = M_INDY;
          3'd5:    m = M_ZPX;
          3'd6:    m = M_ABSY;
          default: m = M_ABSX;
        endcase
      end
      2'b10: begin
        case (bbb)
          3'd0:    m = M_IMM;
          3'd1:    m = M_ZP;
          3'd3:    m = M_ABS;
          3'd5:    m = (aaa == 3'd4 || aaa == 3'd5) ? M_ZPY : M_ZPX;
          3'd7:    m = (aaa == 3'd5) ? M_ABSY : M_ABSX;
          default: m = M_IMP;
        endcase
      end
      2'b00: begin
        case (bbb)
          3'd0: begin
            if (op == 8'h20)
              m = M_ABS;
            else if (op == 8'hA0 || op == 8'hC0 || op == 8'hE0)
              m = M_IMM;
            else
              m = M_IMP;
          end
          3'd1:    m = M_ZP;
          3'd3:    m = (op == 8'h6C) ? M_IND : M_ABS;
          3'd4:    m = M_REL;
          3'd5:    m = M_ZPX;
          3'd7:    m = M_ABSX;
          default: m = M_IMP;
        endcase
      end
      default: m = M_IMP;
    endcase
    return m;
  endfunction

  // Instruction length in bytes.
  function automatic logic [2:0] mode_len(input logic [3:0] m);
    logic [2:0] len;
    case (m)
      M_IMP:                       len = 3'd1;
      M_ABS, M_ABSX, M_ABSY, M_IND: len = 3'd3;
      default:                     len = 3'd2;
    endcase
    return len;
  endfunction

  // Total reads: instruction bytes plus two pointer bytes for indirect modes.
  function automatic logic [2:0] mode_reads(input logic [3:0] m);
    logic [2:0] n;
    n = mode_len(m);
    if (m == M_INDX || m == M_INDY || m == M_IND)
      n = n + 3'd2;
    return n;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q;
  logic [15:0] pc_q;
  logic [7:0]  b1_q, b2_q, p0_q, p1_q;

  logic [7:0]  cap_op, cap_b1, cap_b2;
  logic [3:0]  cap_mode;
  logic [2:0]  cap_len, next_idx;
  logic        cap_last;
  logic [15:0] next_addr;
  logic [7:0]  zp_ptr;
  logic [15:0] res_next, res_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: fixed ISSUE/WAIT/CAPTURE cadence per read, RESOLVE after the last byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (if_start && !halt) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = cap_last ? S_RESOLVE : S_ISSUE;
      S_RESOLVE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // View of the bytes including the one arriving this cycle, so the next read address
  // (which may depend on it) can be registered straight into mem_addr.
  always_comb begin
    cap_op   = (idx_q == 3'd0) ? mem.mem_data_in : opcode;
    cap_b1   = (idx_q == 3'd1) ? mem.mem_data_in : b1_q;
    cap_b2   = (idx_q == 3'd2) ? mem.mem_data_in : b2_q;
    cap_mode = decode_mode(cap_op);
    cap_len  = mode_len(cap_mode);
    next_idx = idx_q + 3'd1;
    cap_last = (next_idx == mode_reads(cap_mode));
    zp_ptr   = cap_b1 + x;
    next_addr = pc_q + {13'd0, next_idx};
    if (next_idx == cap_len) begin
      case (cap_mode)
        M_INDX:  next_addr = {8'h00, zp_ptr};
        M_INDY:  next_addr = {8'h00, cap_b1};
        M_IND:   next_addr = {cap_b2, cap_b1};
        default: next_addr = pc_q + {13'd0, next_idx};
      endcase
    end else if (next_idx == cap_len + 3'd1) begin
      // Second pointer byte stays in the same page: zero-page wrap and the JMP (ind) bug.
      case (cap_mode)
        M_INDX:  next_addr = {8'h00, zp_ptr + 8'd1};
        M_INDY:  next_addr = {8'h00, cap_b1 + 8'd1};
        M_IND:   next_addr = {cap_b2, cap_b1 + 8'd1};
        default: next_addr = pc_q + {13'd0, next_idx};
      endcase
    end
  end

  // Effective address from captured bytes and the current index registers.
  always_comb begin
    res_next = pc_q + {13'd0, mode_len(addr_mode)};
    res_addr = 16'h0000;
    case (addr_mode)
      M_IMM, M_ZP:   res_addr = {8'h00, b1_q};
      M_ZPX:         res_addr = {8'h00, b1_q + x};
      M_ZPY:         res_addr = {8'h00, b1_q + y};
      M_ABS:         res_addr = {b2_q, b1_q};
      M_ABSX:        res_addr = {b2_q, b1_q} + {8'h00, x};
      M_ABSY:        res_addr = {b2_q, b1_q} + {8'h00, y};
      M_INDX, M_IND: res_addr = {p1_q, p0_q};
      M_INDY:        res_addr = {p1_q, p0_q} + {8'h00, y};
      M_REL:         res_addr = res_next + {{8{b1_q[7]}}, b1_q};
      default:       res_addr = 16'h0000;
    endcase
  end

  // Datapath: read issue, byte capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_addr    <= 16'h0000;
      mem.mem_read_en <= 1'b0;
      opcode          <= 8'h00;
      addr_mode       <= M_IMP;
      if_addr_out     <= 16'h0000;
      if_pc_next      <= 16'h0000;
      if_ready        <= 1'b0;
      idx_q           <= 3'd0;
      pc_q            <= 16'h0000;
      b1_q            <= 8'h00;
      b2_q            <= 8'h00;
      p0_q            <= 8'h00;
      p1_q            <= 8'h00;
    end else begin
      mem.mem_read_en <= (state_d == S_ISSUE);
      case (state_q)
        S_IDLE: begin
          if (if_start && !halt) begin
            pc_q         <= pc_in;
            mem.mem_addr <= pc_in;
            idx_q        <= 3'd0;
            if_ready     <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (idx_q == 3'd0) begin
            opcode    <= mem.mem_data_in;
            addr_mode <= cap_mode;
          end else if (idx_q == cap_len) begin
            p0_q <= mem.mem_data_in;
          end else if (idx_q == cap_len + 3'd1) begin
            p1_q <= mem.mem_data_in;
          end else if (idx_q == 3'd1) begin
            b1_q <= mem.mem_data_in;
          end else begin
            b2_q <= mem.mem_data_in;
          end
          if (!cap_last) begin
            idx_q        <= next_idx;
            mem.mem_addr <= next_addr;
          end
        end
        S_RESOLVE: begin
          if_addr_out <= res_addr;
          if_pc_next  <= res_next;
          if_ready    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst, halt, if_start;
  logic [15:0] pc_in;
  logic [7:0]  x, y;
  logic [7:0]  opcode;
  logic [3:0]  addr_mode;
  logic [15:0] if_addr_out, if_pc_next;
  logic        if_ready;

  if_fetch_if mif();

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .if_start    (if_start),
    .pc_in       (pc_in),
    .x           (x),
    .y           (y),
    .mem         (mif),
    .opcode      (opcode),
    .addr_mode   (addr_mode),
    .if_addr_out (if_addr_out),
    .if_pc_next  (if_pc_next),
    .if_ready    (if_ready)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] pulse_addr [$];
  int          pulse_cyc [$];
  logic        rd_vld1 = 1'b0;
  logic [15:0] rd_a1 = 16'h0000;

  // Memory model: data valid exactly two cycles after the read pulse, junk otherwise.
  always @(posedge clk) begin
    cyc             <= cyc + 1;
    rd_vld1         <= mif.mem_read_en;
    rd_a1           <= mif.mem_addr;
    mif.mem_data_in <= rd_vld1 ? mem[rd_a1] : 8'hC3;
  end

  // Log every read pulse with its cycle number.
  always @(negedge clk) begin
    if (mif.mem_read_en) begin
      pulse_addr.push_back(mif.mem_addr);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fetch(input string nm, input logic [15:0] pc, input int len, input int nrd,
                       input logic [15:0] ptr0, input logic [15:0] ptr1,
                       input logic [7:0] exp_op, input logic [3:0] exp_mode,
                       input logic [15:0] exp_addr, input logic [15:0] exp_next);
    int t0;
    int lat;
    logic [15:0] ea;
    @(negedge clk);
    pulse_addr.delete();
    pulse_cyc.delete();
    pc_in    = pc;
    if_start = 1'b1;
    t0       = cyc;
    @(negedge clk);
    if_start = 1'b0;
    pc_in    = 16'h0BAD;
    check({nm, ".rdy_low"}, {31'd0, if_ready}, 32'd0);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (if_ready) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check({nm, ".latency"}, lat, 3 * nrd + 2);
    check({nm, ".npulse"}, pulse_addr.size(), nrd);
    for (int k = 0; k < nrd && k < pulse_addr.size(); k++) begin
      ea = (k < len) ? pc + 16'(k) : ((k == len) ? ptr0 : ptr1);
      check($sformatf("%s.paddr%0d", nm, k), {16'd0, pulse_addr[k]}, {16'd0, ea});
      check($sformatf("%s.pcyc%0d", nm, k), pulse_cyc[k] - t0, 1 + 3 * k);
    end
    check({nm, ".opcode"}, {24'd0, opcode}, {24'd0, exp_op});
    check({nm, ".mode"}, {28'd0, addr_mode}, {28'd0, exp_mode});
    check({nm, ".addr"}, {16'd0, if_addr_out}, {16'd0, exp_addr});
    check({nm, ".next"}, {16'd0, if_pc_next}, {16'd0, exp_next});
    repeat (3) @(negedge clk);
    check({nm, ".hold_rdy"}, {31'd0, if_ready}, 32'd1);
    check({nm, ".hold_addr"}, {16'd0, if_addr_out}, {16'd0, exp_addr});
  endtask

  initial begin
    int t0;
    int lat;
    rst = 1'b1; halt = 1'b0; if_start = 1'b0; pc_in = 16'h0000; x = 8'h00; y = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h8000] = 8'hEA;
    mem[16'hC000] = 8'hAD; mem[16'hC001] = 8'h34; mem[16'hC002] = 8'h12;
    mem[16'h9000] = 8'hB1; mem[16'h9001] = 8'hFF; mem[16'h00FF] = 8'hF8; mem[16'h0000] = 8'h12;
    mem[16'hA000] = 8'h6C; mem[16'hA001] = 8'hFF; mem[16'hA002] = 8'h02;
    mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12; mem[16'h0300] = 8'h99;
    mem[16'hB000] = 8'hBD; mem[16'hB001] = 8'hFF; mem[16'hB002] = 8'hFF;
    mem[16'h8010] = 8'h10; mem[16'h8011] = 8'hF0;
    mem[16'h8100] = 8'hA1; mem[16'h8101] = 8'h20; mem[16'h0025] = 8'hCD; mem[16'h0026] = 8'hAB;
    mem[16'h8200] = 8'hB6; mem[16'h8201] = 8'h80;
    mem[16'h8300] = 8'hA9; mem[16'h8301] = 8'h7F;
    mem[16'hFFFF] = 8'hEA;
    mem[16'h8400] = 8'hBE; mem[16'h8401] = 8'h10; mem[16'h8402] = 8'h20;
    mem[16'h8500] = 8'h0A;
    mem[16'hD000] = 8'hAD; mem[16'hD001] = 8'h78; mem[16'hD002] = 8'h56;

    repeat (3) @(negedge clk);
    check("rst.ready", {31'd0, if_ready}, 32'd0);
    check("rst.rden", {31'd0, mif.mem_read_en}, 32'd0);
    check("rst.maddr", {16'd0, mif.mem_addr}, 32'd0);
    check("rst.opcode", {24'd0, opcode}, 32'd0);
    check("rst.mode", {28'd0, addr_mode}, 32'd0);
    check("rst.addr", {16'd0, if_addr_out}, 32'd0);
    check("rst.next", {16'd0, if_pc_next}, 32'd0);
    rst = 1'b0;

    fetch("imp",   16'h8000, 1, 1, 16'h0000, 16'h0000, 8'hEA, 4'd0,  16'h0000, 16'h8001);
    fetch("abs",   16'hC000, 3, 3, 16'h0000, 16'h0000, 8'hAD, 4'd5,  16'h1234, 16'hC003);
    y = 8'h10;
    fetch("indy",  16'h9000, 2, 4, 16'h00FF, 16'h0000, 8'hB1, 4'd9,  16'h1308, 16'h9002);
    fetch("ind",   16'hA000, 3, 5, 16'h02FF, 16'h0200, 8'h6C, 4'd11, 16'h1234, 16'hA003);
    x = 8'h02;
    fetch("absx",  16'hB000, 3, 3, 16'h0000, 16'h0000, 8'hBD, 4'd6,  16'h0001, 16'hB003);
    fetch("rel",   16'h8010, 2, 2, 16'h0000, 16'h0000, 8'h10, 4'd10, 16'h8002, 16'h8012);
    x = 8'h05;
    fetch("indx",  16'h8100, 2, 4, 16'h0025, 16'h0026, 8'hA1, 4'd8,  16'hABCD, 16'h8102);
    x = 8'h33; y = 8'h90;
    fetch("zpy",   16'h8200, 2, 2, 16'h0000, 16'h0000, 8'hB6, 4'd4,  16'h0010, 16'h8202);
    fetch("imm",   16'h8300, 2, 2, 16'h0000, 16'h0000, 8'hA9, 4'd1,  16'h007F, 16'h8302);
    fetch("pcwrap",16'hFFFF, 1, 1, 16'h0000, 16'h0000, 8'hEA, 4'd0,  16'h0000, 16'h0000);
    x = 8'h70; y = 8'h05;
    fetch("absy",  16'h8400, 3, 3, 16'h0000, 16'h0000, 8'hBE, 4'd7,  16'h2015, 16'h8403);
    fetch("asla",  16'h8500, 1, 1, 16'h0000, 16'h0000, 8'h0A, 4'd0,  16'h0000, 16'h8501);

    // Halt blocks a start while idle.
    @(negedge clk);
    pulse_addr.delete();
    halt = 1'b1; if_start = 1'b1; pc_in = 16'hC000;
    repeat (4) @(negedge clk);
    if_start = 1'b0; halt = 1'b0;
    check("halt.npulse", pulse_addr.size(), 0);
    check("halt.ready", {31'd0, if_ready}, 32'd1);

    // A second start during a fetch is ignored.
    @(negedge clk);
    pulse_addr.delete();
    pc_in = 16'hD000; if_start = 1'b1; t0 = cyc;
    @(negedge clk);
    if_start = 1'b0;
    repeat (3) @(negedge clk);
    if_start = 1'b1; pc_in = 16'h8000;
    @(negedge clk);
    if_start = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (if_ready) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check("restart.latency", lat, 11);
    check("restart.npulse", pulse_addr.size(), 3);
    check("restart.addr", {16'd0, if_addr_out}, 32'h5678);
    check("restart.next", {16'd0, if_pc_next}, 32'hD003);
    check("restart.opcode", {24'd0, opcode}, 32'hAD);

    // Reset between reads aborts the fetch.
    @(negedge clk);
    pc_in = 16'hD000; if_start = 1'b1;
    @(negedge clk);
    if_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_addr.delete();
    check("midrst.ready", {31'd0, if_ready}, 32'd0);
    check("midrst.rden", {31'd0, mif.mem_read_en}, 32'd0);
    check("midrst.maddr", {16'd0, mif.mem_addr}, 32'd0);
    check("midrst.opcode", {24'd0, opcode}, 32'd0);
    check("midrst.mode", {28'd0, addr_mode}, 32'd0);
    check("midrst.addr", {16'd0, if_addr_out}, 32'd0);
    check("midrst.next", {16'd0, if_pc_next}, 32'd0);
    repeat (12) @(negedge clk);
    check("midrst.npulse", pulse_addr.size(), 0);
    check("midrst.ready_late", {31'd0, if_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
